// File: rtl/fmul_d_arb.sv
`default_nettype none
// ============================================================================
// Module   : fmul_d_arb
// Purpose  : Round-robin sequencer sharing one multi-cycle fmul_d unit between
//            up to four requesters, with watchdog timeout and flush.
// Revision : 1.0 - initial release
// ============================================================================
module fmul_d_arb #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [64*NREQ-1:0]   i_req_a,
    input  logic [64*NREQ-1:0]   i_req_b,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [NREQ-1:0]      o_resp_valid,
    output logic [63:0]          o_resp_res,
    output logic                 o_resp_overflow,
    output logic                 o_resp_illegal,
    input  logic                 i_flush,
    output logic                 o_mul_ena,
    output logic [63:0]          o_mul_a,
    output logic [63:0]          o_mul_b,
    input  logic                 i_mul_valid,
    input  logic [63:0]          i_mul_res,
    input  logic                 i_mul_overflow,
    input  logic                 i_mul_illegal,
    output logic                 o_busy
);

    localparam int          c_IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  c_TO_LAST = 4'(TIMEOUT - 1);
    localparam logic [63:0] c_QNAN    = 64'h7FF8_0000_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_IW-1:0]   r_rr_ptr;
    logic [c_IW-1:0]   r_owner;
    logic [3:0]        r_cnt;
    logic [63:0]       r_mul_a;
    logic [63:0]       r_mul_b;
    logic              r_mul_ena;
    logic [NREQ-1:0]   r_resp_valid;
    logic [63:0]       r_resp_res;
    logic              r_resp_ovf;
    logic              r_resp_ill;
    logic              r_busy;

    logic              w_grant;
    logic [c_IW-1:0]   w_grant_idx;
    logic [c_IW-1:0]   w_cand;
    logic [NREQ-1:0]   w_ready;
    logic              w_timeout;
    int                w_scan;

    // Scan starts just past the last owner so every requester gets a turn.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        w_ready     = '0;
        w_scan      = 0;
        if (r_state == S_IDLE) begin
            for (int i = 1; i <= NREQ; i++) begin
                w_scan = (int'(r_rr_ptr) + i) % NREQ;
                w_cand = c_IW'(w_scan);
                if (!w_grant && i_req_valid[w_cand]) begin
                    w_grant         = 1'b1;
                    w_grant_idx     = w_cand;
                    w_ready[w_cand] = 1'b1;
                end
            end
        end
    end

    assign w_timeout = (r_cnt == c_TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= c_IW'(NREQ - 1);
            r_owner      <= '0;
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_ena    <= 1'b0;
            r_resp_valid <= '0;
            r_resp_res   <= '0;
            r_resp_ovf   <= 1'b0;
            r_resp_ill   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mul_ena    <= 1'b0;
            r_resp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_mul_a   <= i_req_a[int'(w_grant_idx)*64 +: 64];
                        r_mul_b   <= i_req_b[int'(w_grant_idx)*64 +: 64];
                        r_owner   <= w_grant_idx;
                        r_rr_ptr  <= w_grant_idx;
                        r_mul_ena <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= i_flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (i_flush) begin
                        // A coincident result or expiry means the unit is already empty.
                        if (i_mul_valid || w_timeout) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                            r_state <= S_DRAIN;
                        end
                    end else if (i_mul_valid) begin
                        r_resp_res            <= i_mul_res;
                        r_resp_ovf            <= i_mul_overflow;
                        r_resp_ill            <= i_mul_illegal;
                        r_resp_valid[r_owner] <= 1'b1;
                        r_state               <= S_RESP;
                    end else if (w_timeout) begin
                        r_resp_res            <= c_QNAN;
                        r_resp_ovf            <= 1'b0;
                        r_resp_ill            <= 1'b1;
                        r_resp_valid[r_owner] <= 1'b1;
                        r_state               <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (i_mul_valid || w_timeout) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready     = w_ready;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_res      = r_resp_res;
    assign o_resp_overflow = r_resp_ovf;
    assign o_resp_illegal  = r_resp_ill;
    assign o_mul_ena       = r_mul_ena;
    assign o_mul_a         = r_mul_a;
    assign o_mul_b         = r_mul_b;
    assign o_busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fmul_d_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_d_arb
// Purpose  : Directed self-checking bench for the fmul_d round-robin sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmul_d_arb;

    localparam logic [63:0] c_ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] c_TWO   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] c_THREE = 64'h4008_0000_0000_0000;
    localparam logic [63:0] c_FOUR  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] c_SIX   = 64'h4018_0000_0000_0000;
    localparam logic [63:0] c_QNAN  = 64'h7FF8_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [1:0]   req_ready;
    logic [1:0]   resp_valid;
    logic [63:0]  resp_res;
    logic         resp_ovf;
    logic         resp_ill;
    logic         flush;
    logic         mul_ena;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic         mul_valid;
    logic [63:0]  mul_res;
    logic         mul_ovf;
    logic         mul_ill;
    logic         busy;

    int checks = 0;
    int errors = 0;

    fmul_d_arb #(.NREQ(2), .TIMEOUT(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready), .o_resp_valid(resp_valid),
        .o_resp_res(resp_res), .o_resp_overflow(resp_ovf), .o_resp_illegal(resp_ill),
        .i_flush(flush), .o_mul_ena(mul_ena), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_valid(mul_valid), .i_mul_res(mul_res),
        .i_mul_overflow(mul_ovf), .i_mul_illegal(mul_ill), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Each tick lands 1 time unit after a rising edge: inputs change and outputs settle there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; flush = 0; mul_valid = 0; mul_ovf = 0; mul_ill = 0;
        mul_res = '0; req_a = '0; req_b = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b exp 00", resp_valid); end
        checks++; if ({mul_ena, busy, resp_ovf, resp_ill} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {mul_ena, busy, resp_ovf, resp_ill}); end
        checks++; if ({mul_a, mul_b, resp_res} !== 192'd0) begin errors++; $display("FAIL reset_data: got %h %h %h exp 0", mul_a, mul_b, resp_res); end
    endtask

    task automatic test_single();
        req_valid = 2'b01; req_a[63:0] = c_TWO; req_b[63:0] = c_THREE;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (mul_ena !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_issue: got ena=%b busy=%b exp 1 1", mul_ena, busy); end
        checks++; if (mul_a !== c_TWO || mul_b !== c_THREE) begin errors++; $display("FAIL single_operands: got %h %h exp %h %h", mul_a, mul_b, c_TWO, c_THREE); end
        tick();
        checks++; if (mul_ena !== 1'b0) begin errors++; $display("FAIL single_ena_pulse: got %b exp 0", mul_ena); end
        repeat (4) tick();
        mul_valid = 1'b1; mul_res = c_SIX;
        tick();
        mul_valid = 1'b0;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL single_resp_valid: got %b exp 01", resp_valid); end
        checks++; if (resp_res !== c_SIX || resp_ovf !== 1'b0 || resp_ill !== 1'b0) begin errors++; $display("FAIL single_resp_data: got %h %b %b exp %h 0 0", resp_res, resp_ovf, resp_ill, c_SIX); end
        tick();
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got rv=%b busy=%b exp 00 0", resp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [63:0] exp_a;
        logic [63:0] exp_r;
        rst = 1'b1; tick(); rst = 1'b0;
        req_a = {c_THREE, c_TWO}; req_b = {c_TWO, c_TWO}; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_a   = (k % 2 == 0) ? c_TWO : c_THREE;
            exp_r   = (k % 2 == 0) ? c_FOUR : c_SIX;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, req_ready, exp_rdy); end
            tick();
            checks++; if (mul_a !== exp_a) begin errors++; $display("FAIL rr_operand%0d: got %h exp %h", k, mul_a, exp_a); end
            for (int j = 1; j <= 6; j++) begin
                if (j == 6) begin mul_valid = 1'b1; mul_res = exp_r; end
                #1;
                checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_busy_ready%0d_%0d: got %b exp 00", k, j, req_ready); end
                tick();
            end
            mul_valid = 1'b0;
            checks++; if (resp_valid !== exp_rdy || resp_res !== exp_r) begin errors++; $display("FAIL rr_resp%0d: got %b %h exp %b %h", k, resp_valid, resp_res, exp_rdy, exp_r); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_resp_ready%0d: got %b exp 00", k, req_ready); end
            tick();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        req_valid = 2'b10; req_a[127:64] = c_ONE;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL to_ready: got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b00;
        repeat (15) tick();
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL to_early: got rv=%b busy=%b exp 00 1", resp_valid, busy); end
        tick();
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL to_resp_valid: got %b exp 10", resp_valid); end
        checks++; if (resp_res !== c_QNAN || resp_ill !== 1'b1 || resp_ovf !== 1'b0) begin errors++; $display("FAIL to_resp_data: got %h ovf=%b ill=%b exp %h 0 1", resp_res, resp_ovf, resp_ill, c_QNAN); end
        tick();
    endtask

    task automatic test_flush();
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fl_ready: got %b exp 01", req_ready); end
        tick(); req_valid = 2'b00;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_drain_busy: got %b exp 1", busy); end
        tick(); tick();
        mul_valid = 1'b1; mul_res = c_FOUR;
        tick();
        mul_valid = 1'b0;
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL fl_no_resp: got rv=%b busy=%b exp 00 0", resp_valid, busy); end
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fl_reaccept: got %b exp 01", req_ready); end
        tick(); req_valid = 2'b00;
        repeat (5) tick();
        flush = 1'b1; mul_valid = 1'b1; mul_res = c_SIX;
        tick();
        flush = 1'b0; mul_valid = 1'b0;
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL fl_coincident: got rv=%b busy=%b exp 00 0", resp_valid, busy); end
        tick();
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL fl_coincident_late: got %b exp 00", resp_valid); end
    endtask

    task automatic test_valid_timeout();
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL vt_ready: got %b exp 10", req_ready); end
        tick(); req_valid = 2'b00;
        repeat (15) tick();
        mul_valid = 1'b1; mul_res = c_FOUR; mul_ovf = 1'b1;
        tick();
        mul_valid = 1'b0; mul_ovf = 1'b0;
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL vt_resp_valid: got %b exp 10", resp_valid); end
        checks++; if (resp_res !== c_FOUR || resp_ill !== 1'b0 || resp_ovf !== 1'b1) begin errors++; $display("FAIL vt_resp_data: got %h ovf=%b ill=%b exp %h 1 0", resp_res, resp_ovf, resp_ill, c_FOUR); end
        tick();
    endtask

    task automatic test_flush_issue();
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fi_ready: got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00; flush = 1'b1;
        checks++; if (mul_ena !== 1'b1) begin errors++; $display("FAIL fi_ena: got %b exp 1", mul_ena); end
        tick(); flush = 1'b0;
        repeat (4) tick();
        mul_valid = 1'b1;
        tick();
        mul_valid = 1'b0;
        checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL fi_no_resp: got rv=%b busy=%b exp 00 0", resp_valid, busy); end
    endtask

    task automatic test_reset_mid();
        req_valid = 2'b01; req_a[63:0] = c_THREE;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_ready: got %b exp 01", req_ready); end
        tick(); req_valid = 2'b00;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy, mul_ena, resp_valid, resp_ovf, resp_ill} !== 6'b0) begin errors++; $display("FAIL rm_flags: got %b exp 000000", {busy, mul_ena, resp_valid, resp_ovf, resp_ill}); end
        checks++; if ({mul_a, mul_b, resp_res} !== 192'd0) begin errors++; $display("FAIL rm_data: got %h %h %h exp 0", mul_a, mul_b, resp_res); end
        tick(); tick();
        mul_valid = 1'b1; mul_res = c_SIX;
        tick();
        mul_valid = 1'b0;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rm_late_valid: got %b exp 00", resp_valid); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b exp 01", req_ready); end
        tick(); req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_flush();
        test_valid_timeout();
        test_flush_issue();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
